gaussian_ctrl_p: RTL and testbench

Parametrised successor to the fixed-size Gaussian blur controller. It sequences a KxK Gaussian convolution over an IMG_W x IMG_H frame held in a single-port pixel memory. It generates read addresses and line-buffer shift strobes, flags valid windows, and produces delay-aligned write addresses for the MAC pipeline. It adds a start/busy/done handshake, downstream throttling, and an optional zero-border fill pass.

---
 rtl/gaussian_pkg.sv | 30 +++
 rtl/gc_delay_line.sv | 35 +++
 rtl/gaussian_ctrl_p.sv | 186 ++++++++++++++++++
 tb/tb_gaussian_ctrl_p.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gaussian_pkg.sv
// Shared types and derived-constant helpers for the parametrised Gaussian blur controller.
// Helpers are functions so each instance derives its constants from its own parameters.
package gaussian_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_BORDER = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  function automatic int calc_r(input int k);
    return (k - 1) / 2;
  endfunction

  function automatic int calc_npix(input int w, input int h);
    return w * h;
  endfunction

  function automatic int calc_nint(input int w, input int h, input int k);
    return (w - k + 1) * (h - k + 1);
  endfunction

  // Bits needed to count 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gc_delay_line.sv
// Fixed-depth valid+address shift register.
// Aligns window-centre addresses with the MAC pipeline output.
module gc_delay_line #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic [DEPTH-1:0]  valid_sr;
  logic [ADDR_W-1:0] addr_sr [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_sr <= '0;
      for (int i = 0; i < DEPTH; i++) addr_sr[i] <= '0;
    end else begin
      valid_sr[0] <= in_valid;
      addr_sr[0]  <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        addr_sr[i]  <= addr_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[DEPTH-1];
  assign out_addr  = addr_sr[DEPTH-1];

endmodule

// File: rtl/gaussian_ctrl_p.sv
// Sequencer for a KxK Gaussian convolution over an IMG_W x IMG_H frame, with optional
// zero-border fill pass and start/busy/done handshake.
//
//   state  | meaning
//   IDLE   | waiting for start; mode latched on start
//   RUN    | raster reads, line-buffer shifts, window flags
//   FLUSH  | draining the MAC pipeline for the final interior write
//   BORDER | raster scan writing zeros to the R-wide frame border
//   FIN    | one-cycle done pulse
module gaussian_ctrl_p
  import gaussian_pkg::*;
#(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int K        = 3,
  parameter int ADDR_W   = 12,
  parameter int PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              lb_shift,
  output logic              lb_row_start,
  output logic              win_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_zero
);

  localparam int R     = calc_r(K);
  localparam int NPIX  = calc_npix(IMG_W, IMG_H);
  localparam int RD_W  = cnt_w(NPIX + 1);
  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H + 1);
  localparam int FT_W  = cnt_w(PIPE_LAT);

  localparam logic [RD_W-1:0]   RD_END   = RD_W'(NPIX);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] CTR_OFF  = ADDR_W'(R * IMG_W + R);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0]  COL_WIN  = COL_W'(K - 1);
  localparam logic [ROW_W-1:0]  ROW_WIN  = ROW_W'(K - 1);
  localparam logic [COL_W-1:0]  COL_LO   = COL_W'(R);
  localparam logic [COL_W-1:0]  COL_HI   = COL_W'(IMG_W - R);
  localparam logic [ROW_W-1:0]  ROW_LO   = ROW_W'(R);
  localparam logic [ROW_W-1:0]  ROW_HI   = ROW_W'(IMG_H - R);
  localparam logic [FT_W-1:0]   FT_LOAD  = FT_W'(PIPE_LAT - 1);

  state_t            state_q, state_d;
  logic              mode_q;
  logic [RD_W-1:0]   rd_cnt;
  logic              lb_shift_q;
  logic [COL_W-1:0]  in_col;
  logic [ROW_W-1:0]  in_row;
  logic [ADDR_W-1:0] in_pix;
  logic [FT_W-1:0]   flush_tmr;

  logic              rd_go;
  logic              border_wr;
  logic              pix_last;
  logic              in_border;
  logic              adv;
  logic              cnt_clr;
  logic              start_acc;
  logic [ADDR_W-1:0] centre;
  logic              dl_valid;
  logic [ADDR_W-1:0] dl_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rd_go     = 1'b0;
    border_wr = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy  = 1'b1;
        rd_go = out_ready && (rd_cnt < RD_END);
        if (lb_shift_q && pix_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (flush_tmr == '0) state_d = mode_q ? ST_BORDER : ST_FIN;
      end
      ST_BORDER: begin
        busy      = 1'b1;
        border_wr = out_ready && in_border;
        if (out_ready && pix_last) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign start_acc = (state_q == ST_IDLE) && start;
  assign pix_last  = (in_pix == PIX_LAST);
  assign in_border = (in_row < ROW_LO) || (in_row >= ROW_HI) ||
                     (in_col < COL_LO) || (in_col >= COL_HI);

  // The same column/row/pixel counters track incoming pixels in RUN and the scan in BORDER.
  assign adv     = ((state_q == ST_RUN) && lb_shift_q) ||
                   ((state_q == ST_BORDER) && out_ready);
  assign cnt_clr = start_acc || (state_q == ST_FIN) ||
                   ((state_q == ST_FLUSH) && (flush_tmr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= 1'b0;
      rd_cnt     <= '0;
      lb_shift_q <= 1'b0;
      in_col     <= '0;
      in_row     <= '0;
      in_pix     <= '0;
      flush_tmr  <= '0;
    end else begin
      lb_shift_q <= rd_go;

      if (start_acc) mode_q <= mode;

      if (start_acc || (state_q == ST_FIN)) rd_cnt <= '0;
      else if (rd_go)                       rd_cnt <= rd_cnt + RD_W'(1);

      if (cnt_clr) begin
        in_col <= '0;
        in_row <= '0;
        in_pix <= '0;
      end else if (adv) begin
        in_pix <= in_pix + ADDR_W'(1);
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= in_row + ROW_W'(1);
        end else begin
          in_col <= in_col + COL_W'(1);
        end
      end

      if ((state_q == ST_RUN) && (state_d == ST_FLUSH))
        flush_tmr <= FT_LOAD;
      else if ((state_q == ST_FLUSH) && (flush_tmr != '0))
        flush_tmr <= flush_tmr - FT_W'(1);
    end
  end

  assign rd_en        = rd_go;
  assign rd_addr      = (state_q == ST_RUN) ? ADDR_W'(rd_cnt) : '0;
  assign lb_shift     = lb_shift_q;
  assign lb_row_start = lb_shift_q && (in_col == '0);
  assign win_valid    = lb_shift_q && (in_row >= ROW_WIN) && (in_col >= COL_WIN);

  // Window centre sits R rows and R columns behind the incoming pixel.
  assign centre = in_pix - CTR_OFF;

  gc_delay_line #(
    .DEPTH  (PIPE_LAT),
    .ADDR_W (ADDR_W)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (win_valid),
    .in_addr   (centre),
    .out_valid (dl_valid),
    .out_addr  (dl_addr)
  );

  assign wr_en   = dl_valid || border_wr;
  assign wr_zero = border_wr;
  assign wr_addr = border_wr ? in_pix : (dl_valid ? dl_addr : '0);

endmodule

// File: tb/tb_gaussian_ctrl_p.sv
// Self-checking bench for gaussian_ctrl_p: 8x6 K=3 instance plus an 8x8 K=5 instance.
// Expected write sequences are queued at frame start and consumed as writes appear.
module tb_gaussian_ctrl_p;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int KK = 3;
  localparam int RR = (KK - 1) / 2;
  localparam int PL = 4;
  localparam int W5 = 8;
  localparam int H5 = 8;
  localparam int K5 = 5;
  localparam int R5 = (K5 - 1) / 2;

  typedef struct packed {
    logic [11:0] addr;
    logic        zero;
  } exp_t;

  logic clk, rst;
  logic start, mode, out_ready;
  logic busy, done, rd_en, lb_shift, lb_row_start, win_valid, wr_en, wr_zero;
  logic [11:0] rd_addr, wr_addr;
  logic start5, mode5, out_ready5;
  logic busy5, done5, rd_en5, lb_shift5, lb_row_start5, win_valid5, wr_en5, wr_zero5;
  logic [11:0] rd_addr5, wr_addr5;

  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];
  exp_t q5[$];
  int exp_rd, sh_cnt, cyc, win_cyc, n_int, n_bor, n_done, done_base;
  logic seen_win, seen_wr, prev_rd_en, prev_busy;
  logic [11:0] prev_rd_addr;
  int n_wr5, n_done5;
  logic seen_win5, seen_wr5, prev_rd_en5;
  logic [11:0] prev_rd_addr5;

  gaussian_ctrl_p #(.IMG_W(W), .IMG_H(H), .K(KK), .ADDR_W(12), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .out_ready(out_ready),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .lb_shift(lb_shift),
    .lb_row_start(lb_row_start), .win_valid(win_valid), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_zero(wr_zero)
  );

  gaussian_ctrl_p #(.IMG_W(W5), .IMG_H(H5), .K(K5), .ADDR_W(12), .PIPE_LAT(PL)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .mode(mode5), .out_ready(out_ready5),
    .busy(busy5), .done(done5), .rd_en(rd_en5), .rd_addr(rd_addr5), .lb_shift(lb_shift5),
    .lb_row_start(lb_row_start5), .win_valid(win_valid5), .wr_en(wr_en5),
    .wr_addr(wr_addr5), .wr_zero(wr_zero5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int expv);
    n_chk++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Interior centres in raster order, then (mode 1) every border pixel in raster order.
  task automatic build_exp(input logic m);
    q.delete();
    for (int r = RR; r < H - RR; r++)
      for (int c = RR; c < W - RR; c++)
        q.push_back('{addr: 12'(r * W + c), zero: 1'b0});
    if (m)
      for (int a = 0; a < W * H; a++)
        if ((a / W) < RR || (a / W) >= H - RR || (a % W) < RR || (a % W) >= W - RR)
          q.push_back('{addr: 12'(a), zero: 1'b1});
  endtask

  task automatic start_frame(input logic m);
    build_exp(m);
    exp_rd = 0; sh_cnt = 0; seen_win = 1'b0; seen_wr = 1'b0;
    n_int = 0; n_bor = 0; done_base = n_done;
    @(posedge clk); #1;
    start = 1'b1; mode = m;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0;
    check_eq("busy_rise", int'(busy), 1);
  endtask

  task automatic wait_rd(input int a);
    int n;
    n = 0;
    while (!(rd_en && rd_addr == 12'(a)) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_eq("rd_reached", int'(rd_addr), a);
  endtask

  task automatic finish_frame(input logic m);
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check_eq("done_seen", int'(done), 1);
    @(negedge clk); #1;
    check_eq("wr_left", q.size(), 0);
    check_eq("done_count", n_done - done_base, 1);
    check_eq("wr_interior", n_int, 24);
    check_eq("wr_border", n_bor, m ? 24 : 0);
    check_eq("rd_total", exp_rd, W * H);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int col, row;
    cyc++;
    if (!rst) begin
      sh_cnt = 0; prev_rd_en = 1'b0; prev_rd_addr = '0; prev_busy = 1'b0;
    end else begin
      if (rd_en) begin
        check_eq("rd_addr", int'(rd_addr), exp_rd);
        exp_rd++;
      end
      if (!out_ready) check_eq("rd_throttle", int'(rd_en), 0);
      if (lb_shift || prev_rd_en) check_eq("lb_shift", int'(lb_shift), int'(prev_rd_en));
      if (lb_shift || win_valid || lb_row_start) begin
        col = sh_cnt % W;
        row = sh_cnt / W;
        check_eq("row_start", int'(lb_row_start), int'(lb_shift && col == 0));
        check_eq("win_valid", int'(win_valid),
                 int'(lb_shift && row >= KK - 1 && col >= KK - 1));
      end
      if (win_valid && !seen_win) begin
        seen_win = 1'b1;
        win_cyc = cyc;
        check_eq("first_win_rd", int'(prev_rd_addr), (KK - 1) * W + (KK - 1));
      end
      if (lb_shift) sh_cnt++;
      if (wr_en) begin
        if (!seen_wr) begin
          seen_wr = 1'b1;
          check_eq("wr_latency", cyc - win_cyc, PL);
        end
        if (q.size() == 0) begin
          check_eq("wr_extra", int'(wr_en), 0);
        end else begin
          e = q.pop_front();
          check_eq("wr_addr", int'(wr_addr), int'(e.addr));
          check_eq("wr_zero", int'(wr_zero), int'(e.zero));
        end
        if (wr_zero) n_bor++;
        else         n_int++;
      end
      if (done) begin
        n_done++;
        check_eq("busy_at_done", int'(busy), 0);
        check_eq("busy_before_done", int'(prev_busy), 1);
      end
      prev_rd_en = rd_en; prev_rd_addr = rd_addr; prev_busy = busy;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_rd_en5 = 1'b0; prev_rd_addr5 = '0;
    end else begin
      if (lb_shift5 || prev_rd_en5) check_eq("k5_lb_shift", int'(lb_shift5), int'(prev_rd_en5));
      if (lb_row_start5) check_eq("k5_row_start", int'(lb_shift5), 1);
      if (win_valid5 && !seen_win5) begin
        seen_win5 = 1'b1;
        check_eq("k5_first_win_rd", int'(prev_rd_addr5), (K5 - 1) * W5 + (K5 - 1));
      end
      if (wr_en5) begin
        if (!seen_wr5) begin
          seen_wr5 = 1'b1;
          check_eq("k5_first_wr", int'(wr_addr5), R5 * W5 + R5);
        end
        if (q5.size() == 0) begin
          check_eq("k5_wr_extra", int'(wr_en5), 0);
        end else begin
          e = q5.pop_front();
          check_eq("k5_wr_addr", int'(wr_addr5), int'(e.addr));
        end
        check_eq("k5_wr_zero", int'(wr_zero5), 0);
        n_wr5++;
      end
      if (done5) begin
        n_done5++;
        check_eq("k5_busy_at_done", int'(busy5), 0);
      end
      prev_rd_en5 = rd_en5; prev_rd_addr5 = rd_addr5;
    end
  end

  initial begin
    int n, sh_sum;
    rst = 1'b0; start = 1'b0; mode = 1'b0; out_ready = 1'b1;
    start5 = 1'b0; mode5 = 1'b0; out_ready5 = 1'b1;
    cyc = 0; n_done = 0; done_base = 0; win_cyc = 0;
    n_wr5 = 0; n_done5 = 0; seen_win5 = 1'b0; seen_wr5 = 1'b0;
    #2;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_rd_en", int'(rd_en), 0);
    check_eq("rst_rd_addr", int'(rd_addr), 0);
    check_eq("rst_lb_shift", int'(lb_shift), 0);
    check_eq("rst_win_valid", int'(win_valid), 0);
    check_eq("rst_wr_en", int'(wr_en), 0);
    check_eq("rst_wr_addr", int'(wr_addr), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // interior only
    start_frame(1'b0);
    finish_frame(1'b0);

    // interior plus border fill
    start_frame(1'b1);
    finish_frame(1'b1);

    // throttle mid-row
    start_frame(1'b0);
    wait_rd(20);
    @(posedge clk); #1;
    out_ready = 1'b0;
    sh_sum = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("thr_rd_en", int'(rd_en), 0);
      sh_sum += int'(lb_shift);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check_eq("thr_trailing", sh_sum, 1);
    finish_frame(1'b0);

    // start while busy and on the FIN cycle
    start_frame(1'b0);
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check_eq("s4_done_seen", int'(done), 1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("s4_busy", int'(busy), 0);
    check_eq("s4_done_count", n_done - done_base, 1);
    check_eq("s4_rd_total", exp_rd, W * H);
    check_eq("s4_wr_left", q.size(), 0);
    check_eq("s4_wr_interior", n_int, 24);

    // reset mid-frame
    start_frame(1'b0);
    wait_rd(30);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("s5_busy", int'(busy), 0);
    check_eq("s5_rd_en", int'(rd_en), 0);
    check_eq("s5_rd_addr", int'(rd_addr), 0);
    check_eq("s5_lb_shift", int'(lb_shift), 0);
    check_eq("s5_win_valid", int'(win_valid), 0);
    check_eq("s5_wr_en", int'(wr_en), 0);
    check_eq("s5_wr_addr", int'(wr_addr), 0);
    q.delete();
    done_base = n_done;
    repeat (3) @(posedge clk);
    #1;
    check_eq("s5_no_done", n_done - done_base, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    check_eq("s5_idle_busy", int'(busy), 0);
    start_frame(1'b0);
    finish_frame(1'b0);

    // K=5 on 8x8
    q5.delete();
    for (int r = R5; r < H5 - R5; r++)
      for (int c = R5; c < W5 - R5; c++)
        q5.push_back('{addr: 12'(r * W5 + c), zero: 1'b0});
    @(posedge clk); #1 start5 = 1'b1;
    @(posedge clk); #1 start5 = 1'b0;
    check_eq("k5_busy_rise", int'(busy5), 1);
    n = 0;
    while (!done5 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check_eq("k5_done_seen", int'(done5), 1);
    @(negedge clk); #1;
    check_eq("k5_wr_count", n_wr5, 16);
    check_eq("k5_wr_left", q5.size(), 0);
    check_eq("k5_done_count", n_done5, 1);
    check_eq("k5_win_seen", int'(seen_win5), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
